noc_packetizer: RTL and testbench
=================================

NOC_PACKETIZER -- requirements
Module: noc_packetizer

Interface
REQ-001 SHALL have parameter SRC_X, default 0, 2-bit X coordinate of the local node.
REQ-002 SHALL have parameter SRC_Y, default 0, 2-bit Y coordinate of the local node.
REQ-003 SHALL have parameter WIDTH, default 32, packet width; no other value is supported.
REQ-004 SHALL have parameter DEPTH, default 4, request FIFO depth; power of two, 2 to 16.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-007 SHALL have port req_valid, input, 1, PE request valid.
REQ-008 SHALL have port req_ready, output, 1, request accepted on an edge where valid and ready are both high.
REQ-009 SHALL have port req_payload, input, 24, PE data word.
REQ-010 SHALL have port req_mcast, input, 1; 1 selects req_mask, 0 selects req_dst.
REQ-011 SHALL have port req_dst, input, 4, unicast node id: [3:2]=Y, [1:0]=X.
REQ-012 SHALL have port req_mask, input, 16, multicast set; bit i is node id i.
REQ-013 SHALL have port pkt_valid, output, 1, packet valid toward the router PE input.
REQ-014 SHALL have port pkt_ready, input, 1, router accepts the packet.
REQ-015 SHALL have port pkt_data, output, 32, the packet.
REQ-016 SHALL have port busy, output, 1, high when the FIFO or the engine holds work.
REQ-017 SHALL have port drop_cnt, output, 8, count of dropped requests; saturates at 255.

Function
REQ-018 Packet format SHALL be [31:30]=SRC_X, [29:28]=SRC_Y, [27:26]=dst X, [25:24]=dst Y, [23:0]=payload.
REQ-019 At enqueue, a unicast request SHALL be stored as a one-hot mask of req_dst, so every FIFO entry is {payload, mask}.
REQ-020 At enqueue, the local node bit ({SRC_Y,SRC_X}) SHALL be cleared from the mask.
REQ-021 req_ready SHALL equal (FIFO count < DEPTH); there is no full-FIFO bypass, including when a pop occurs on the same edge.
REQ-022 The engine SHALL have states IDLE and EMIT.
REQ-023 IDLE to EMIT SHALL occur when the FIFO is non-empty and the output register is free.
REQ-024 EMIT to IDLE SHALL occur when the last packet of the entry handshakes and the FIFO is empty.
REQ-025 If the last packet handshakes and the FIFO is non-empty, the engine SHALL stay in EMIT and pop the next entry on that same edge.
REQ-026 Destinations of an entry SHALL be emitted in ascending node-id order, one packet per accepted cycle.
REQ-027 Each emitted destination's bit SHALL be cleared on its pkt handshake.
REQ-028 The output register SHALL load whenever (!pkt_valid || pkt_ready) and a destination is pending.
REQ-029 pkt_valid and pkt_data SHALL be held stable while pkt_valid=1 and pkt_ready=0.
REQ-030 Latency SHALL be 2 edges from request accept to pkt_valid=1 (empty FIFO, idle engine); sustained throughput SHALL be 1 packet/cycle with pkt_ready=1.
REQ-031 An entry whose mask is zero at pop SHALL produce no packet, SHALL consume one engine cycle, and SHALL increment drop_cnt (saturating).
REQ-032 busy SHALL be (FIFO count != 0) || pkt_valid || (engine state == EMIT).

Reset
REQ-033 While rst_n=0 at a clock edge: FIFO empty, engine IDLE, pkt_valid=0, pkt_data=0, drop_cnt=0, busy=0.
REQ-034 req_ready SHALL be 0 during reset and 1 on the first cycle after rst_n rises.
REQ-035 Reset asserted mid-multicast SHALL discard all pending destinations and entries; no partial packet is emitted afterwards.

Structure
REQ-036 Shared package noc_pkg SHALL hold header field bit positions, the node_id_t (4-bit) type, the payload width (24), and a header-build function.
REQ-037 The FIFO SHALL be a separate sub-module pkt_fifo (parameterised width and depth, synchronous reset, count output).
REQ-038 Lowest-set-bit selection SHALL be combinational inside noc_packetizer.

Verification
REQ-039 Unicast: SRC=(0,0), req_dst=4'b0110, payload 24'hABCDEF, pkt_ready=1 -> pkt_data=32'h09ABCDEF exactly 2 edges after accept, exactly once.
REQ-040 Multicast: SRC=(1,1), mask 16'h0033 -> packets to ids 0, 1, 4 in that order (id 5 is self, removed), consecutive cycles, payload identical.
REQ-041 Backpressure: pkt_ready=0 for 10 cycles during a multicast -> pkt_data stable throughout; FIFO fills, req_ready=0 after DEPTH accepts; no loss after release.
REQ-042 Drop: unicast to self, then mask 16'h0000 -> no packets, drop_cnt=2; 300 such drops -> drop_cnt=255.
REQ-043 Reset mid-operation: rst_n=0 for 1 edge during the second packet of a 3-destination multicast -> pkt_valid=0, busy=0, no further packets.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared definitions for the NoC packetizer.
// Holds the packet header field positions, node id type, payload width,
// the FIFO entry layout and the header-build helper.
package noc_pkg;

  localparam int PAYLOAD_W = 24;
  localparam int PKT_W     = 32;
  localparam int NODES     = 16;

  // Header field LSB positions; each coordinate field is 2 bits wide.
  localparam int HDR_SX_LO = 30;
  localparam int HDR_SY_LO = 28;
  localparam int HDR_DX_LO = 26;
  localparam int HDR_DY_LO = 24;

  typedef logic [3:0] node_id_t;

  typedef enum logic {ST_IDLE, ST_EMIT} eng_state_t;

  // One queued request: payload plus the destination set still to serve.
  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic [NODES-1:0]     mask;
  } fifo_entry_t;

  localparam int ENTRY_W = PAYLOAD_W + NODES;

  // Node id layout is {Y[1:0], X[1:0]}.
  function automatic logic [PKT_W-1:0] build_pkt(
    input logic [1:0]           sx,
    input logic [1:0]           sy,
    input node_id_t             dst,
    input logic [PAYLOAD_W-1:0] payload
  );
    logic [PKT_W-1:0] p;
    p                   = '0;
    p[HDR_SX_LO +: 2]   = sx;
    p[HDR_SY_LO +: 2]   = sy;
    p[HDR_DX_LO +: 2]   = dst[1:0];
    p[HDR_DY_LO +: 2]   = dst[3:2];
    p[PAYLOAD_W-1:0]    = payload;
    return p;
  endfunction

endpackage

// File: rtl/pkt_fifo.sv
// Request FIFO for the packetizer.
// Ports: clk, rst_n (sync, active low), i_push/i_wdata write side,
// i_pop/o_rdata read side (o_rdata shows the head entry), o_count occupancy.
// Caller guarantees no push when full and no pop when empty.
module pkt_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic [AW:0]      o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  // Storage needs no reset; occupancy tracking alone defines validity.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/noc_packetizer.sv
// NoC packetizer: turns PE requests (unicast or multicast) into one 32-bit
// packet per destination toward the local router input.
// Ports: clk, rst_n (sync, active low); req_* valid/ready request side with
// payload, mcast select, unicast dst and multicast mask; pkt_* valid/ready
// packet side; busy (work held anywhere); drop_cnt (saturating count of
// entries that had no destination left).
module noc_packetizer
  import noc_pkg::*;
#(
  parameter logic [1:0] SRC_X = 2'd0,
  parameter logic [1:0] SRC_Y = 2'd0,
  parameter int         WIDTH = 32,
  parameter int         DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [23:0]      req_payload,
  input  logic             req_mcast,
  input  logic [3:0]       req_dst,
  input  logic [15:0]      req_mask,
  output logic             pkt_valid,
  input  logic             pkt_ready,
  output logic [WIDTH-1:0] pkt_data,
  output logic             busy,
  output logic [7:0]       drop_cnt
);

  localparam int                CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
  localparam node_id_t          SELF_ID = {SRC_Y, SRC_X};

  eng_state_t       r_state;
  logic [NODES-1:0] r_mask;
  logic [23:0]      r_payload;
  logic             r_pkt_valid;
  logic [WIDTH-1:0] r_pkt_data;
  logic [7:0]       r_drop_cnt;

  logic [CW-1:0]        w_count;
  logic [ENTRY_W-1:0]   w_rdata;
  fifo_entry_t          w_head;
  fifo_entry_t          w_in;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_empty;
  logic                 w_free;
  logic [NODES-1:0]     w_src_mask;
  logic [23:0]          w_src_payload;
  logic [NODES-1:0]     w_rest;
  node_id_t             w_sel_id;
  logic                 w_sel_vld;

  // Enqueue side: unicast becomes one-hot, self is never a destination.
  assign req_ready     = rst_n && (w_count < DEPTH_C);
  assign w_push        = req_valid && req_ready;
  assign w_in.payload  = req_payload;
  assign w_in.mask     = (req_mcast ? req_mask : (16'h1 << req_dst)) & ~(16'h1 << SELF_ID);

  pkt_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (w_in),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_count (w_count)
  );

  assign w_head  = fifo_entry_t'(w_rdata);
  assign w_empty = (w_count == '0);
  assign w_free  = !r_pkt_valid || pkt_ready;

  // Pop when the current entry has nothing left to load: the head is then
  // forwarded straight into the output register on the same edge, giving
  // 2-edge latency and back-to-back entries without a bubble.
  assign w_pop = !w_empty && w_free && ((r_state == ST_IDLE) || (r_mask == '0));

  assign w_src_mask    = w_pop ? w_head.mask    : r_mask;
  assign w_src_payload = w_pop ? w_head.payload : r_payload;

  // Lowest set bit -> ascending node-id emission order.
  always_comb begin
    w_sel_id  = '0;
    w_sel_vld = |w_src_mask;
    for (int i = NODES - 1; i >= 0; i--) begin
      if (w_src_mask[i]) w_sel_id = node_id_t'(i);
    end
  end

  assign w_rest = w_src_mask & ~(16'h1 << w_sel_id);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_mask      <= '0;
      r_payload   <= '0;
      r_pkt_valid <= 1'b0;
      r_pkt_data  <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (w_pop) r_payload <= w_head.payload;
      if (w_pop && (w_head.mask == '0) && (r_drop_cnt != 8'hFF))
        r_drop_cnt <= r_drop_cnt + 8'd1;
      // Output register advances only when empty or being accepted; a
      // destination leaves r_mask as it enters the output register.
      if (w_free) begin
        r_pkt_valid <= w_sel_vld;
        r_state     <= w_sel_vld ? ST_EMIT : ST_IDLE;
        if (w_sel_vld) begin
          r_pkt_data <= WIDTH'(build_pkt(SRC_X, SRC_Y, w_sel_id, w_src_payload));
          r_mask     <= w_rest;
        end
      end
    end
  end

  assign pkt_valid = r_pkt_valid;
  assign pkt_data  = r_pkt_data;
  assign drop_cnt  = r_drop_cnt;
  assign busy      = !w_empty || r_pkt_valid || (r_state == ST_EMIT);

endmodule

// File: tb/tb_noc_packetizer.sv
module tb_noc_packetizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid0, req_valid1;
  logic [23:0] req_payload;
  logic        req_mcast;
  logic [3:0]  req_dst;
  logic [15:0] req_mask;
  logic        pkt_ready;

  logic        req_ready0, pkt_valid0, busy0;
  logic [31:0] pkt_data0;
  logic [7:0]  drop_cnt0;
  logic        req_ready1, pkt_valid1, busy1;
  logic [31:0] pkt_data1;
  logic [7:0]  drop_cnt1;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  always #5 clk = ~clk;

  noc_packetizer #(.SRC_X(2'd0), .SRC_Y(2'd0), .WIDTH(32), .DEPTH(4)) u0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_payload(req_payload), .req_mcast(req_mcast), .req_dst(req_dst), .req_mask(req_mask),
    .pkt_valid(pkt_valid0), .pkt_ready(pkt_ready), .pkt_data(pkt_data0),
    .busy(busy0), .drop_cnt(drop_cnt0));

  noc_packetizer #(.SRC_X(2'd1), .SRC_Y(2'd1), .WIDTH(32), .DEPTH(4)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_payload(req_payload), .req_mcast(req_mcast), .req_dst(req_dst), .req_mask(req_mask),
    .pkt_valid(pkt_valid1), .pkt_ready(pkt_ready), .pkt_data(pkt_data1),
    .busy(busy1), .drop_cnt(drop_cnt1));

  // Record every packet handshake seen by each DUT.
  always @(posedge clk) begin
    if (pkt_valid0 && pkt_ready) q0.push_back(pkt_data0);
    if (pkt_valid1 && pkt_ready) q1.push_back(pkt_data1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid0 = 0; req_valid1 = 0; req_payload = '0;
    req_mcast = 0; req_dst = '0; req_mask = '0; pkt_ready = 1'b1;
    tick; tick; tick;
    n_tests++; if (req_ready1 !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready: got %b want 0", req_ready1); end
    n_tests++; if (pkt_valid1 !== 1'b0) begin n_fail++; $display("FAIL rst_pkt_valid: got %b want 0", pkt_valid1); end
    n_tests++; if (pkt_data1 !== 32'h0) begin n_fail++; $display("FAIL rst_pkt_data: got %h want 0", pkt_data1); end
    n_tests++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy1); end
    n_tests++; if (drop_cnt1 !== 8'd0) begin n_fail++; $display("FAIL rst_drop_cnt: got %0d want 0", drop_cnt1); end
    rst_n = 1'b1;
    #1;
    n_tests++; if (req_ready1 !== 1'b1 || req_ready0 !== 1'b1) begin n_fail++; $display("FAIL post_rst_req_ready: got %b%b want 11", req_ready0, req_ready1); end
  endtask

  task automatic test_unicast;
    q0.delete();
    pkt_ready = 1'b1;
    req_mcast = 1'b0; req_dst = 4'b0110; req_payload = 24'hABCDEF; req_valid0 = 1'b1;
    tick;  // accept edge
    req_valid0 = 1'b0;
    n_tests++; if (pkt_valid0 !== 1'b0) begin n_fail++; $display("FAIL uni_early_valid: got %b want 0", pkt_valid0); end
    tick;
    n_tests++; if (pkt_valid0 !== 1'b1 || pkt_data0 !== 32'h09ABCDEF) begin n_fail++; $display("FAIL uni_pkt: got v=%b %h want v=1 09abcdef", pkt_valid0, pkt_data0); end
    tick;
    n_tests++; if (pkt_valid0 !== 1'b0) begin n_fail++; $display("FAIL uni_after_valid: got %b want 0", pkt_valid0); end
    tick; tick;
    n_tests++; if (q0.size() != 1) begin n_fail++; $display("FAIL uni_count: got %0d want 1", q0.size()); end
    n_tests++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL uni_busy: got %b want 0", busy0); end
  endtask

  task automatic test_multicast;
    logic [31:0] exp [3];
    exp[0] = 32'h50123456; exp[1] = 32'h54123456; exp[2] = 32'h51123456;
    q1.delete();
    pkt_ready = 1'b1;
    req_mcast = 1'b1; req_mask = 16'h0033; req_payload = 24'h123456; req_valid1 = 1'b1;
    tick;
    req_valid1 = 1'b0;
    n_tests++; if (pkt_valid1 !== 1'b0) begin n_fail++; $display("FAIL mc_early_valid: got %b want 0", pkt_valid1); end
    for (int i = 0; i < 3; i++) begin
      tick;
      n_tests++; if (pkt_valid1 !== 1'b1 || pkt_data1 !== exp[i]) begin n_fail++; $display("FAIL mc_pkt%0d: got v=%b %h want v=1 %h", i, pkt_valid1, pkt_data1, exp[i]); end
    end
    tick;
    n_tests++; if (pkt_valid1 !== 1'b0 || busy1 !== 1'b0) begin n_fail++; $display("FAIL mc_done: got v=%b busy=%b want 0 0", pkt_valid1, busy1); end
    n_tests++; if (q1.size() != 3) begin n_fail++; $display("FAIL mc_count: got %0d want 3", q1.size()); end
  endtask

  task automatic test_backpressure;
    logic [31:0] exp [7];
    int   n;
    logic rdy;
    logic stable_ok;
    int   guard;
    exp[0] = 32'h50AAAAAA; exp[1] = 32'h54AAAAAA; exp[2] = 32'h51AAAAAA;
    exp[3] = 32'h58000001; exp[4] = 32'h58000002; exp[5] = 32'h58000003; exp[6] = 32'h58000004;
    q1.delete();
    pkt_ready = 1'b0;
    req_mcast = 1'b1; req_mask = 16'h0013; req_payload = 24'hAAAAAA; req_valid1 = 1'b1;
    tick;
    n = 0; stable_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req_mcast = 1'b0; req_dst = 4'd2; req_payload = 24'(n + 1); req_valid1 = 1'b1;
      rdy = req_ready1;
      tick;
      if (rdy) n++;
      if (pkt_valid1 !== 1'b1 || pkt_data1 !== 32'h50AAAAAA) stable_ok = 1'b0;
    end
    req_valid1 = 1'b0;
    n_tests++; if (!stable_ok) begin n_fail++; $display("FAIL bp_stable: got v=%b %h want v=1 50aaaaaa", pkt_valid1, pkt_data1); end
    n_tests++; if (n != 4) begin n_fail++; $display("FAIL bp_accepts: got %0d want 4", n); end
    n_tests++; if (req_ready1 !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready: got %b want 0", req_ready1); end
    n_tests++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL bp_busy: got %b want 1", busy1); end
    pkt_ready = 1'b1;
    guard = 0;
    while ((busy1 || pkt_valid1) && guard < 60) begin tick; guard++; end
    n_tests++; if (guard >= 60) begin n_fail++; $display("FAIL bp_drain_timeout: got busy=%b want 0", busy1); end
    n_tests++; if (q1.size() != 7) begin n_fail++; $display("FAIL bp_count: got %0d want 7", q1.size()); end
    for (int i = 0; i < 7; i++) begin
      if (i < q1.size()) begin
        n_tests++; if (q1[i] !== exp[i]) begin n_fail++; $display("FAIL bp_pkt%0d: got %h want %h", i, q1[i], exp[i]); end
      end
    end
  endtask

  task automatic test_drop;
    q1.delete();
    pkt_ready = 1'b1;
    req_mcast = 1'b0; req_dst = 4'd5; req_payload = 24'h000001; req_valid1 = 1'b1;
    tick;
    req_mcast = 1'b1; req_mask = 16'h0000;
    tick;
    req_valid1 = 1'b0;
    tick; tick;
    n_tests++; if (drop_cnt1 !== 8'd2) begin n_fail++; $display("FAIL drop_two: got %0d want 2", drop_cnt1); end
    n_tests++; if (q1.size() != 0) begin n_fail++; $display("FAIL drop_no_pkt: got %0d want 0", q1.size()); end
    n_tests++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL drop_busy: got %b want 0", busy1); end
    req_valid1 = 1'b1;
    for (int i = 0; i < 298; i++) tick;
    req_valid1 = 1'b0;
    tick; tick; tick;
    n_tests++; if (drop_cnt1 !== 8'd255) begin n_fail++; $display("FAIL drop_sat: got %0d want 255", drop_cnt1); end
    n_tests++; if (q1.size() != 0) begin n_fail++; $display("FAIL drop_sat_no_pkt: got %0d want 0", q1.size()); end
  endtask

  task automatic test_reset_mid;
    q1.delete();
    pkt_ready = 1'b1;
    req_mcast = 1'b1; req_mask = 16'h0013; req_payload = 24'h777777; req_valid1 = 1'b1;
    tick;
    req_valid1 = 1'b0;
    tick;
    tick;
    n_tests++; if (pkt_valid1 !== 1'b1 || pkt_data1 !== 32'h54777777) begin n_fail++; $display("FAIL rm_second: got v=%b %h want v=1 54777777", pkt_valid1, pkt_data1); end
    rst_n = 1'b0; pkt_ready = 1'b0;
    q1.delete();
    tick;
    rst_n = 1'b1;
    n_tests++; if (pkt_valid1 !== 1'b0 || busy1 !== 1'b0) begin n_fail++; $display("FAIL rm_cleared: got v=%b busy=%b want 0 0", pkt_valid1, busy1); end
    n_tests++; if (pkt_data1 !== 32'h0 || drop_cnt1 !== 8'd0) begin n_fail++; $display("FAIL rm_regs: got %h drop=%0d want 0 0", pkt_data1, drop_cnt1); end
    pkt_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick;
    n_tests++; if (q1.size() != 0 || pkt_valid1 !== 1'b0) begin n_fail++; $display("FAIL rm_no_more: got %0d pkts v=%b want 0 0", q1.size(), pkt_valid1); end
  endtask

  initial begin
    test_reset;
    test_unicast;
    test_multicast;
    test_backpressure;
    test_drop;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
